// File: rtl/baud_pkg.sv
// Shared types and default constants for the UART baud scheduler.
package baud_pkg;

    localparam int unsigned DIV_W   = 32;
    localparam int unsigned DEF_DIV = 78;
    localparam int unsigned OVS     = 16;
    localparam int unsigned SUB_W   = $clog2(OVS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/baud_sched_if.sv
// Divisor configuration handshake between a host and the baud scheduler.
interface baud_sched_if #(
    parameter int unsigned DIV_W = 32
);

    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/baud_tick_cnt.sv
// Prescale counter: counts 0..div_eff-1 while run is high and flags the wrap cycle.
module baud_tick_cnt #(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div_eff,
    output logic             wrap
);

    logic [DIV_W-1:0] cnt;

    assign wrap = run && (cnt == div_eff - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/baud_sched.sv
// UART baud scheduler: owns the divisor, sequences the prescaler and emits
// registered 16x-oversample and 1x bit-rate tick enables.
module baud_sched
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned DEF_DIV = 78,
    parameter int unsigned OVS     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    baud_sched_if.slave      cfg,
    output logic             tick_x16,
    output logic             tick_x1,
    output logic             running,
    output logic [DIV_W-1:0] div_q
);

    localparam int unsigned SUB_W = $clog2(OVS);

    state_t           state;
    state_t           state_nx;
    logic [SUB_W-1:0] sub;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] div_eff;
    logic             wrap;
    logic             last;
    logic             hs;
    logic             cnt_run;
    logic             cnt_clr;

    assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    assign hs      = cfg.cfg_valid && cfg.cfg_ready;
    assign cnt_run = (state != IDLE) && en;
    assign cnt_clr = (state == IDLE) || !en;
    // Bit boundary: the prescaler wrap that also wraps the oversample counter.
    assign last    = wrap && (sub == SUB_W'(OVS - 1));

    baud_tick_cnt #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .run     (cnt_run),
        .div_eff (div_eff),
        .wrap    (wrap)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (en) state_nx = RUN;
            RUN:  if (!en) state_nx = IDLE; else if (hs) state_nx = PEND;
            PEND: if (!en) state_nx = IDLE; else if (last) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sub       <= '0;
            pend_div  <= '0;
            div_q     <= DIV_W'(DEF_DIV);
            tick_x16  <= 1'b0;
            tick_x1   <= 1'b0;
            running   <= 1'b0;
            cfg.cfg_ready <= 1'b1;
        end else begin
            state         <= state_nx;
            running       <= (state_nx != IDLE);
            cfg.cfg_ready <= (state_nx != PEND);
            tick_x16      <= wrap;
            tick_x1       <= last;

            if (cnt_clr) begin
                sub <= '0;
            end else if (wrap) begin
                sub <= sub + SUB_W'(1);
            end

            if (state == RUN && en && hs) begin
                pend_div <= cfg.cfg_div;
            end

            // Direct writes happen only when no tick stream is (or stays) active;
            // a stopping PEND flushes its captured divisor rather than dropping it.
            if (hs && (state == IDLE || (state == RUN && !en))) begin
                div_q <= cfg.cfg_div;
            end else if (state == PEND && (!en || last)) begin
                div_q <= pend_div;
            end
        end
    end

endmodule

// File: tb/tb_baud_sched.sv
// Randomized self-checking bench for baud_sched against a tick-time reference model.
module tb_baud_sched;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEF = 78;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          tick_x16;
    logic          tick_x1;
    logic          running;
    logic [DW-1:0] div_q;

    baud_sched_if #(.DIV_W(DW)) cfg ();

    baud_sched #(
        .DIV_W   (DW),
        .DEF_DIV (DEF),
        .OVS     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg      (cfg),
        .tick_x16 (tick_x16),
        .tick_x1  (tick_x1),
        .running  (running),
        .div_q    (div_q)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: ticks fall at multiples of div (x16) and 16*div (x1) counted from an epoch edge.
    longint unsigned cyc = 0;
    longint unsigned epoch = 0;
    longint unsigned ediv = 1;
    bit              m_run;
    bit              m_pend;
    logic [DW-1:0]   m_div;
    logic [DW-1:0]   m_pend_div;
    bit              e_x16;
    bit              e_x1;
    bit              e_rdy;

    function automatic longint unsigned eff(input logic [DW-1:0] d);
        return (d == '0) ? 64'd1 : longint'(d);
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_div = DW'(DEF); m_pend_div = '0;
        e_x16 = 0; e_x1 = 0; e_rdy = 1;
    endtask

    task automatic model_edge();
        bit hs;
        longint unsigned k;
        hs = cfg.cfg_valid && e_rdy;
        e_x16 = 0;
        e_x1  = 0;
        if (!m_run) begin
            if (hs) m_div = cfg.cfg_div;
            if (en) begin
                m_run = 1; epoch = cyc; ediv = eff(m_div);
            end
        end else if (!en) begin
            if (m_pend) m_div = m_pend_div;
            else if (hs) m_div = cfg.cfg_div;
            m_run = 0; m_pend = 0;
        end else begin
            k = cyc - epoch;
            e_x16 = (k % ediv) == 0;
            e_x1  = (k % (16 * ediv)) == 0;
            if (e_x1 && m_pend) begin
                m_div = m_pend_div; m_pend = 0; epoch = cyc; ediv = eff(m_div);
            end
            if (hs) begin
                m_pend = 1; m_pend_div = cfg.cfg_div;
            end
        end
        e_rdy = !(m_run && m_pend);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_div = '0;
        model_reset();
        #12;
        n_checks++;
        if ({tick_x16, tick_x1, running} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ticks got x16=%b x1=%b run=%b exp 000", tick_x16, tick_x1, running);
        end
        n_checks++;
        if (cfg.cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b exp 1", cfg.cfg_ready);
        end
        n_checks++;
        if (div_q !== DW'(DEF)) begin
            n_fail++; $display("FAIL reset_div got %0d exp %0d", div_q, DEF);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default_run();
        int x1_cnt = 0;
        en = 1'b1;
        for (int i = 0; i < 2600; i++) begin
            step();
            if (tick_x1 === 1'b1) x1_cnt++;
            n_checks++;
            if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {e_x16, e_x1, m_run, e_rdy, m_div}) begin
                n_fail++;
                $display("FAIL default_run cyc=%0d got x16=%b x1=%b run=%b rdy=%b div=%0d exp x16=%b x1=%b run=%b rdy=%b div=%0d",
                         cyc, tick_x16, tick_x1, running, cfg.cfg_ready, div_q, e_x16, e_x1, m_run, e_rdy, m_div);
            end
        end
        n_checks++;
        if (x1_cnt != 2600 / (16 * DEF)) begin
            n_fail++; $display("FAIL default_x1_count got %0d exp %0d", x1_cnt, 2600 / (16 * DEF));
        end
    endtask

    task automatic test_update();
        int unsigned wait_n;
        wait_n = $urandom_range(100, 600);
        for (int unsigned i = 0; i < wait_n + 1700; i++) begin
            if (i == wait_n) begin
                cfg.cfg_valid = 1'b1; cfg.cfg_div = DW'(10);
            end else begin
                cfg.cfg_valid = 1'b0;
            end
            step();
            n_checks++;
            if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {e_x16, e_x1, m_run, e_rdy, m_div}) begin
                n_fail++;
                $display("FAIL update cyc=%0d got x16=%b x1=%b run=%b rdy=%b div=%0d exp x16=%b x1=%b run=%b rdy=%b div=%0d",
                         cyc, tick_x16, tick_x1, running, cfg.cfg_ready, div_q, e_x16, e_x1, m_run, e_rdy, m_div);
            end
        end
        n_checks++;
        if (div_q !== DW'(10)) begin
            n_fail++; $display("FAIL update_div got %0d exp 10", div_q);
        end
    endtask

    task automatic test_div_edges();
        for (int d = 0; d < 2; d++) begin
            int c16 = 0;
            int c1  = 0;
            en = 1'b0;
            step();
            cfg.cfg_valid = 1'b1; cfg.cfg_div = DW'(d);
            step();
            cfg.cfg_valid = 1'b0;
            en = 1'b1;
            for (int i = 0; i < 60; i++) begin
                step();
                if (tick_x16 === 1'b1) c16++;
                if (tick_x1 === 1'b1) c1++;
                n_checks++;
                if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {e_x16, e_x1, m_run, e_rdy, m_div}) begin
                    n_fail++;
                    $display("FAIL div_edge d=%0d cyc=%0d got x16=%b x1=%b run=%b rdy=%b div=%0d exp x16=%b x1=%b run=%b rdy=%b div=%0d",
                             d, cyc, tick_x16, tick_x1, running, cfg.cfg_ready, div_q, e_x16, e_x1, m_run, e_rdy, m_div);
                end
            end
            n_checks++;
            if (c16 != 59 || c1 != 3) begin
                n_fail++; $display("FAIL div_edge_counts d=%0d got x16=%0d x1=%0d exp x16=59 x1=3", d, c16, c1);
            end
        end
    endtask

    task automatic test_simul();
        int guard = 0;
        en = 1'b0;
        step();
        cfg.cfg_valid = 1'b1; cfg.cfg_div = DW'(4);
        step();
        cfg.cfg_valid = 1'b0;
        en = 1'b1;
        step();
        while (((cyc + 1 - epoch) % 64) != 0 && guard < 200) begin
            step(); guard++;
        end
        cfg.cfg_valid = 1'b1; cfg.cfg_div = DW'(8);
        step();
        cfg.cfg_valid = 1'b0;
        n_checks++;
        if (tick_x1 !== 1'b1 || cfg.cfg_ready !== 1'b0 || div_q !== DW'(4)) begin
            n_fail++; $display("FAIL simul_wrap got x1=%b rdy=%b div=%0d exp x1=1 rdy=0 div=4", tick_x1, cfg.cfg_ready, div_q);
        end
        for (int i = 0; i < 200; i++) begin
            step();
            n_checks++;
            if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {e_x16, e_x1, m_run, e_rdy, m_div}) begin
                n_fail++;
                $display("FAIL simul cyc=%0d got x16=%b x1=%b run=%b rdy=%b div=%0d exp x16=%b x1=%b run=%b rdy=%b div=%0d",
                         cyc, tick_x16, tick_x1, running, cfg.cfg_ready, div_q, e_x16, e_x1, m_run, e_rdy, m_div);
            end
        end
    endtask

    task automatic test_en_drop();
        int guard = 0;
        while (((cyc + 1 - epoch) % 128) != 10 && guard < 300) begin
            step(); guard++;
        end
        cfg.cfg_valid = 1'b1; cfg.cfg_div = DW'(20);
        step();
        cfg.cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (cfg.cfg_ready !== 1'b0 || div_q !== DW'(8)) begin
            n_fail++; $display("FAIL en_drop_pend got rdy=%b div=%0d exp rdy=0 div=8", cfg.cfg_ready, div_q);
        end
        en = 1'b0;
        step();
        n_checks++;
        if (div_q !== DW'(20) || running !== 1'b0 || cfg.cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL en_drop got div=%0d run=%b rdy=%b exp div=20 run=0 rdy=1", div_q, running, cfg.cfg_ready);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {e_x16, e_x1, m_run, e_rdy, m_div}) begin
                n_fail++;
                $display("FAIL en_drop_idle cyc=%0d got x16=%b x1=%b run=%b rdy=%b div=%0d exp x16=%b x1=%b run=%b rdy=%b div=%0d",
                         cyc, tick_x16, tick_x1, running, cfg.cfg_ready, div_q, e_x16, e_x1, m_run, e_rdy, m_div);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        for (int i = 0; i < 30; i++) step();
        cfg.cfg_valid = 1'b1; cfg.cfg_div = DW'(5);
        step();
        cfg.cfg_valid = 1'b0;
        step();
        n_checks++;
        if (cfg.cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL areset_pend got rdy=%b exp 0", cfg.cfg_ready);
        end
        #3;
        en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {1'b0, 1'b0, 1'b0, 1'b1, DW'(DEF)}) begin
            n_fail++;
            $display("FAIL areset got x16=%b x1=%b run=%b rdy=%b div=%0d exp 0 0 0 1 %0d",
                     tick_x16, tick_x1, running, cfg.cfg_ready, div_q, DEF);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 1400; i++) begin
            en = (i >= 10);
            step();
            n_checks++;
            if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {e_x16, e_x1, m_run, e_rdy, m_div}) begin
                n_fail++;
                $display("FAIL areset_after cyc=%0d got x16=%b x1=%b run=%b rdy=%b div=%0d exp x16=%b x1=%b run=%b rdy=%b div=%0d",
                         cyc, tick_x16, tick_x1, running, cfg.cfg_ready, div_q, e_x16, e_x1, m_run, e_rdy, m_div);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            cfg.cfg_valid = ($urandom_range(0, 29) == 0);
            cfg.cfg_div   = DW'($urandom_range(0, 6));
            step();
            n_checks++;
            if ({tick_x16, tick_x1, running, cfg.cfg_ready, div_q} !== {e_x16, e_x1, m_run, e_rdy, m_div}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got x16=%b x1=%b run=%b rdy=%b div=%0d exp x16=%b x1=%b run=%b rdy=%b div=%0d",
                         cyc, tick_x16, tick_x1, running, cfg.cfg_ready, div_q, e_x16, e_x1, m_run, e_rdy, m_div);
            end
        end
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_update();
        test_div_edges();
        test_simul();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_sched.md
# baud_sched

UART baud scheduler. It owns the prescaler divisor and sequences the single-clock prescaler counter. It generates one-cycle 16x-oversample and 1x bit-rate tick enables for the UART TX/RX engines. Divisor changes arrive over a valid/ready config handshake and take effect only on a bit boundary, so no tick period is ever truncated.

## Interface
- `DIV_W`, 32: divisor width.
- `DEF_DIV`, 78: divisor loaded at reset (clk cycles per `tick_x16`).
- `OVS`, 16: oversample ratio, fixed at 16 (power of two).
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: run request; level-sensitive.
- `cfg_valid` in 1: new divisor offered.
- `cfg_div` in DIV_W: offered divisor.
- `cfg_ready` out 1: scheduler can accept a divisor.
- `tick_x16` out 1: one-cycle pulse every `div_eff` cycles.
- `tick_x1` out 1: one-cycle pulse every 16 `tick_x16`.
- `running` out 1: state is RUN or PEND.
- `div_q` out DIV_W: divisor currently in effect.

## Operation
- `div_eff` = `div_q` if `div_q` ≥ 1; otherwise 1. Divisor 0 and divisor 1 both tick every cycle.
- **Registers:**
  - `cnt` (DIV_W): prescale counter.
  - `sub` (4 bit): oversample counter.
  - `pend_div` (DIV_W): captured divisor awaiting application.
  - `state`.
- **IDLE:**
  - `cnt`=0, `sub`=0; no ticks.
  - `cfg_ready`=1; a handshake writes `div_q` directly.
  - `en`=1 → RUN.
- **RUN:**
  - `cnt` increments; it wraps to 0 when `cnt == div_eff-1`.
  - At wrap, `tick_x16` is registered high for the next cycle and `sub` increments mod 16.
  - `tick_x1` is registered high together with `tick_x16` when `sub` wraps 15→0.
  - `cfg_ready`=1; a handshake loads `pend_div` → PEND.
- **PEND:**
  - Counting continues with the old `div_q`; `cfg_ready`=0.
  - On the wrap that produces `tick_x1`: `div_q` ← `pend_div`, `cnt`/`sub` restart at 0 → RUN.
- `en`=0 in RUN or PEND → IDLE on the next edge. Counters clear; any tick already registered still completes its single cycle. A pending divisor is written to `div_q` on the same edge.
- **Simultaneous events:**
  - A handshake on the same edge as a `tick_x1` wrap is captured into PEND. It applies at the following `tick_x1` boundary, not the current one.
  - `en` falling on the same edge as a handshake in RUN: the divisor goes to `div_q` directly and the state becomes IDLE.
- The config handshake completes on an edge where `cfg_valid && cfg_ready`. `cfg_div` is sampled on that edge only.
- **Reset values (any time, including mid-operation):**
  - `state`=IDLE, `cnt`=0, `sub`=0, `pend_div`=0.
  - `div_q`=DEF_DIV, `tick_x16`=0, `tick_x1`=0, `running`=0, `cfg_ready`=1.

## Timing
- Let edge E0 be the edge that samples `en`=1 in IDLE.
  - `running` is high from E0.
  - `tick_x16` first rises at E0+`div_eff`, then every `div_eff` cycles, exactly one cycle wide.
  - `tick_x1` first rises at E0+16·`div_eff` and coincides with a `tick_x16`.
- `cfg_ready` drops at the edge after the accepting handshake in RUN. It re-rises at the edge that applies `pend_div`.
- After an update applied at edge Ea, the next `tick_x16` is at Ea+`new_div_eff` and the next `tick_x1` is at Ea+16·`new_div_eff`.
- `en`=0 sampled at edge Ed: `running`=0 after Ed. No tick rises after Ed+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Package `baud_pkg`:**
  - `state_t` enum {IDLE, RUN, PEND}.
  - Constants DIV_W, DEF_DIV, OVS, and SUB_W=$clog2(OVS).
- **Sub-module `baud_tick_cnt`:**
  - Inputs: `clr`, `run`, `div_eff`.
  - Outputs: `wrap`; contains `cnt`.
  - The scheduler FSM, `sub`, and the divisor registers stay in `baud_sched`.

## Test plan
- **Reset and default run:** reset, then `en`=1 with DEF_DIV=78 → `tick_x16` every 78 cycles, `tick_x1` every 1248 cycles. Check all reset values.
- **Update at bit boundary:** in RUN, offer `cfg_div`=10 mid-bit → `cfg_ready` low until the next `tick_x1`, then `div_q`=10 and ticks every 10/160 cycles. Old ticks keep 78-cycle spacing before the switch.
- **Divisor edge cases:** `cfg_div`=0 and `cfg_div`=1 in IDLE → `tick_x16` every cycle and `tick_x1` every 16 cycles after `en`.
- **Simultaneous handshake and `tick_x1` wrap:** `div_q`=4, offer 8 on the wrap edge → first 8-cycle period starts only after the next `tick_x1` (64 cycles later).
- **`en` drop with pending divisor:** drop `en` during PEND with `pend_div`=20 → IDLE next edge, `div_q`=20, no further ticks, `cfg_ready`=1.
- **Async reset mid-PEND:** assert `rst_n` low mid-PEND, not clock-aligned → outputs clear immediately, `div_q`=78, pending divisor discarded.
